// File: rtl/tc_interval_timer_if.sv
// Configuration and status bundle for tc_interval_timer.
// master drives cfg_* requests; slave (the timer) drives ready and status.
interface tc_interval_timer_if #(
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CW-1:0]        cfg_chan;
    logic [BIT_WIDTH-1:0] cfg_period;
    logic                 cfg_periodic;
    logic                 cfg_stop;
    logic [CHANNELS-1:0]  expire;
    logic [CHANNELS-1:0]  active;
    logic [CW-1:0]        cur_chan;
    logic [BIT_WIDTH-1:0] cur_value;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_period,
        output cfg_periodic,
        output cfg_stop,
        input  cfg_ready,
        input  expire,
        input  active,
        input  cur_chan,
        input  cur_value
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_period,
        input  cfg_periodic,
        input  cfg_stop,
        output cfg_ready,
        output expire,
        output active,
        output cur_chan,
        output cur_value
    );
endinterface

// File: rtl/tc_interval_timer.sv
// Multi-channel interval timer sharing one decrement datapath via a
// round-robin slot scheduler (one channel serviced per clock).
// Ports: clk, rst (async, active-high), bus (slave: cfg valid/ready
// request, expire/active/cur_chan/cur_value status).
// Optional: TC_TIMER_HOLD_EN adds input hold, which freezes the slot
// pointer, counts and cur_* while still accepting configuration.
module tc_interval_timer #(
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef TC_TIMER_HOLD_EN
    input  logic hold,
`endif
    tc_interval_timer_if.slave bus
);

    localparam int CW = $clog2(CHANNELS);
    localparam logic [CW-1:0]        LAST = CW'(CHANNELS - 1);
    localparam logic [BIT_WIDTH-1:0] ONE  = BIT_WIDTH'(1);

    logic hold_w;
`ifdef TC_TIMER_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Per-channel state
    logic [BIT_WIDTH-1:0] count_q  [CHANNELS];
    logic [BIT_WIDTH-1:0] count_d  [CHANNELS];
    logic [BIT_WIDTH-1:0] period_q [CHANNELS];
    logic [BIT_WIDTH-1:0] period_d [CHANNELS];
    logic [CHANNELS-1:0]  periodic_q;
    logic [CHANNELS-1:0]  periodic_d;
    logic [CHANNELS-1:0]  active_q;
    logic [CHANNELS-1:0]  active_d;

    // Scheduler and registered outputs
    logic [CW-1:0]        slot_q;
    logic [CW-1:0]        slot_d;
    logic [CHANNELS-1:0]  expire_q;
    logic [CHANNELS-1:0]  expire_d;
    logic [CW-1:0]        cur_chan_q;
    logic [CW-1:0]        cur_chan_d;
    logic [BIT_WIDTH-1:0] cur_value_q;
    logic [BIT_WIDTH-1:0] cur_value_d;

    logic                 cfg_ready_w;
    logic                 cfg_fire;
    logic                 cfg_in_range;
    logic [BIT_WIDTH-1:0] cfg_load;
    logic [BIT_WIDTH-1:0] svc_count;

    // Refusing writes to the channel in service removes the only
    // write/service collision; the slot moves on next cycle.
    assign cfg_ready_w  = !rst && (bus.cfg_chan != slot_q);
    assign cfg_in_range = int'(bus.cfg_chan) < CHANNELS;
    assign cfg_fire     = bus.cfg_valid && cfg_ready_w && cfg_in_range;
    assign cfg_load     = (bus.cfg_period == '0) ? ONE : bus.cfg_period;
    assign svc_count    = count_q[slot_q];

    always_comb begin
        count_d     = count_q;
        period_d    = period_q;
        periodic_d  = periodic_q;
        active_d    = active_q;
        slot_d      = slot_q;
        expire_d    = '0;
        cur_chan_d  = cur_chan_q;
        cur_value_d = cur_value_q;

        if (!hold_w) begin
            slot_d     = (slot_q == LAST) ? '0 : slot_q + 1'b1;
            cur_chan_d = slot_q;
            if (active_q[slot_q]) begin
                if (svc_count <= ONE) begin
                    expire_d[slot_q] = 1'b1;
                    if (periodic_q[slot_q]) begin
                        count_d[slot_q] = period_q[slot_q];
                    end else begin
                        count_d[slot_q]  = '0;
                        active_d[slot_q] = 1'b0;
                    end
                end else begin
                    count_d[slot_q] = svc_count - ONE;
                end
            end
            cur_value_d = count_d[slot_q];
        end

        // cfg_chan never equals slot_q here, so this cannot
        // overwrite the service update above.
        if (cfg_fire) begin
            if (bus.cfg_stop) begin
                active_d[bus.cfg_chan] = 1'b0;
                count_d[bus.cfg_chan]  = '0;
            end else begin
                active_d[bus.cfg_chan]   = 1'b1;
                count_d[bus.cfg_chan]    = cfg_load;
                period_d[bus.cfg_chan]   = cfg_load;
                periodic_d[bus.cfg_chan] = bus.cfg_periodic;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '{default: '0};
            period_q    <= '{default: '0};
            periodic_q  <= '0;
            active_q    <= '0;
            slot_q      <= '0;
            expire_q    <= '0;
            cur_chan_q  <= '0;
            cur_value_q <= '0;
        end else begin
            count_q     <= count_d;
            period_q    <= period_d;
            periodic_q  <= periodic_d;
            active_q    <= active_d;
            slot_q      <= slot_d;
            expire_q    <= expire_d;
            cur_chan_q  <= cur_chan_d;
            cur_value_q <= cur_value_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_w;
    assign bus.expire    = expire_q;
    assign bus.active    = active_q;
    assign bus.cur_chan  = cur_chan_q;
    assign bus.cur_value = cur_value_q;

endmodule

// File: tb/tb_tc_interval_timer.sv
// Scoreboard bench for tc_interval_timer: stimulus pushes expected
// expiry events, a monitor pops and compares on each expire pulse.
module tb_tc_interval_timer;

    localparam int BW = 8;
    localparam int CH = 4;
    localparam int CW = $clog2(CH);

    typedef struct {
        int chan;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    tc_interval_timer_if #(.BIT_WIDTH(BW), .CHANNELS(CH)) bus ();

    tc_interval_timer #(.BIT_WIDTH(BW), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
`ifdef TC_TIMER_HOLD_EN
        .hold(hold),
`endif
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: cyc = number of rising edges since reset release.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cyc = 0;
            end else begin
                cyc++;
                if (bus.expire !== '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_expire", 32'(bus.expire), 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("expire_chan", 32'(bus.expire), 1 << e.chan);
                        chk("expire_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Edge on which channel c is next serviced after edge n.
    function automatic int next_svc(input int n, input int c);
        int k;
        k = n + 1;
        while (((k - 1) % CH) != c) k++;
        return k;
    endfunction

    task automatic cfg_write(input int ch, input int p, input bit per,
                             input bit stop, output int acc);
        logic r;
        bus.cfg_valid    = 1'b1;
        bus.cfg_chan     = CW'(ch);
        bus.cfg_period   = BW'(p);
        bus.cfg_periodic = per;
        bus.cfg_stop     = stop;
        acc = -1;
        for (int i = 0; i < 4 && acc < 0; i++) begin
            #1;
            r = bus.cfg_ready;
            tick();
            if (r) acc = cyc;
        end
        bus.cfg_valid = 1'b0;
        if (acc < 0) begin
            chk("cfg_accept_timeout", 0, 1);
            acc = cyc;
        end
    endtask

    initial begin
        int acc;
        int acc2;
        int f;

        bus.cfg_valid    = 1'b1;
        bus.cfg_chan     = CW'(1);
        bus.cfg_period   = '0;
        bus.cfg_periodic = 1'b0;
        bus.cfg_stop     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_expire", 32'(bus.expire), 0);
        chk("rst_cur_chan", 32'(bus.cur_chan), 0);
        chk("rst_cur_value", 32'(bus.cur_value), 0);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Idle: slot walks 0,1,2,3,0...
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("idle_cur_chan", 32'(bus.cur_chan), (k - 1) % CH);
            chk("idle_active", 32'(bus.active), 0);
        end

        // ch2 period 3 periodic
        cfg_write(2, 3, 1'b1, 1'b0, acc);
        chk("arm2_active", 32'(bus.active[2]), 1);
        f = next_svc(acc, 2);
        sb.push_back('{chan: 2, cyc: f + 8});
        sb.push_back('{chan: 2, cyc: f + 20});
        sb.push_back('{chan: 2, cyc: f + 32});
        wait_until(f);
        chk("ch2_cur_chan", 32'(bus.cur_chan), 2);
        chk("ch2_val_a", 32'(bus.cur_value), 2);
        wait_until(f + 4);
        chk("ch2_val_b", 32'(bus.cur_value), 1);
        wait_until(f + 8);
        chk("ch2_val_reload", 32'(bus.cur_value), 3);
        wait_until(f + 12);
        chk("ch2_val_c", 32'(bus.cur_value), 2);
        wait_until(f + 33);
        cfg_write(2, 0, 1'b0, 1'b1, acc);
        chk("stop2_active", 32'(bus.active[2]), 0);
        wait_until(f + 48);
        chk("drain_ch2", sb.size(), 0);

        // ch1 period 0 one-shot
        cfg_write(1, 0, 1'b0, 1'b0, acc);
        chk("arm1_active", 32'(bus.active[1]), 1);
        f = next_svc(acc, 1);
        sb.push_back('{chan: 1, cyc: f});
        wait_until(f);
        chk("ch1_cur_chan", 32'(bus.cur_chan), 1);
        chk("ch1_cur_value", 32'(bus.cur_value), 0);
        chk("ch1_active_clr", 32'(bus.active[1]), 0);
        wait_until(f + 8);
        chk("drain_ch1", sb.size(), 0);

        // Request for ch0 while slot is 0
        while ((cyc % CH) != 0) tick();
        bus.cfg_valid    = 1'b1;
        bus.cfg_chan     = CW'(0);
        bus.cfg_period   = BW'(2);
        bus.cfg_periodic = 1'b0;
        bus.cfg_stop     = 1'b0;
        #1;
        chk("clash_ready_low", 32'(bus.cfg_ready), 0);
        tick();
        chk("clash_ready_high", 32'(bus.cfg_ready), 1);
        tick();
        acc = cyc;
        bus.cfg_valid = 1'b0;
        chk("clash_accepted", 32'(bus.active[0]), 1);
        f = next_svc(acc, 0);
        sb.push_back('{chan: 0, cyc: f + 4});
        wait_until(f + 12);
        chk("drain_ch0", sb.size(), 0);

        // ch3 period 5 periodic, stopped after two services
        cfg_write(3, 5, 1'b1, 1'b0, acc);
        f = next_svc(acc, 3);
        wait_until(f);
        chk("ch3_val_a", 32'(bus.cur_value), 4);
        wait_until(f + 4);
        chk("ch3_val_b", 32'(bus.cur_value), 3);
        cfg_write(3, 0, 1'b0, 1'b1, acc);
        chk("stop3_active", 32'(bus.active[3]), 0);
        wait_until(f + 8);
        chk("ch3_stop_chan", 32'(bus.cur_chan), 3);
        chk("ch3_stop_value", 32'(bus.cur_value), 0);
        wait_until(f + 24);
        chk("drain_ch3", sb.size(), 0);

`ifdef TC_TIMER_HOLD_EN
        // ch0 period 2, hold for 7 cycles after its first service
        cfg_write(0, 2, 1'b0, 1'b0, acc);
        f = next_svc(acc, 0);
        wait_until(f);
        hold = 1'b1;
        cfg_write(2, 1, 1'b0, 1'b0, acc2);
        chk("hold_cfg_accept_cyc", acc2, f + 1);
        chk("hold_cfg_active", 32'(bus.active[2]), 1);
        wait_until(f + 4);
        chk("hold_cur_chan", 32'(bus.cur_chan), 0);
        chk("hold_cur_value", 32'(bus.cur_value), 1);
        wait_until(f + 7);
        hold = 1'b0;
        sb.push_back('{chan: 2, cyc: f + 9});
        sb.push_back('{chan: 0, cyc: f + 11});
        wait_until(f + 16);
        chk("drain_hold", sb.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tc_interval_timer.md
# tc_interval_timer

Multi-channel interval timer that time-shares one decrementing counter datapath among CHANNELS independent timers. A round-robin slot scheduler services exactly one channel per clock. Requesters arm or stop channels through a valid/ready configuration port. Each channel reports expiry as a one-cycle pulse. The block sits beside the counter primitives and gives the design periodic and one-shot ticks without instantiating one counter per consumer.

## Interface
- BIT_WIDTH, 8: width of period and count values.
- CHANNELS, 4: number of timer channels; legal range 2..8.
- CW, $clog2(CHANNELS): channel index width (derived, not overridden).

- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cfg_valid  input  1  configuration request present.
- cfg_ready  output  1  configuration accepted this cycle when high together with cfg_valid.
- cfg_chan  input  CW  target channel.
- cfg_period  input  BIT_WIDTH  period in service slots; 0 treated as 1.
- cfg_periodic  input  1  1 = reload on expiry, 0 = one-shot.
- cfg_stop  input  1  1 = disarm channel; period and mode are ignored.
- expire  output  CHANNELS  one-cycle expiry pulse per channel.
- active  output  CHANNELS  channel armed.
- cur_chan  output  CW  channel serviced in the previous cycle (registered).
- cur_value  output  BIT_WIDTH  count of cur_chan after that service (registered).
- hold  input  1  present only with TC_TIMER_HOLD_EN.

## Operation
- Per-channel state: count[BIT_WIDTH], period[BIT_WIDTH], periodic bit, active bit.
- The slot pointer advances 0,1,...,CHANNELS-1,0 once per clk, independent of activity.
- Service of channel s = slot while active[s]:
  - If count ≤ 1: expire[s] pulses on the next cycle. If periodic, count reloads to period and the channel stays active. Otherwise count goes to 0 and active clears.
  - Otherwise count decrements by 1. The arithmetic is BIT_WIDTH wide; no wrap can occur because count ≥ 2 before any decrement.
- An inactive channel in its slot does not change. cur_chan and cur_value still update.
- Configuration arbitration:
  - cfg_ready = !rst && (cfg_chan != slot). A write never collides with service of the same channel.
  - Accepted arm sets period and count to max(cfg_period,1), sets the periodic bit, and sets active.
  - Accepted stop clears active and sets count to 0. No expire pulse is produced.
  - Re-arming an active channel restarts it; the old count is discarded.
- A request held while cfg_ready is low must stay stable until accepted. It is accepted no later than the next cycle, because the slot moves on.
- Period P: the first expire pulse occurs on the P-th service slot after acceptance. Periodic channels then expire every P×CHANNELS cycles.

## Timing
- Reset values:
  - expire = 0, active = 0, cur_chan = 0, cur_value = 0.
  - All counts, periods and periodic bits = 0; slot = 0.
  - cfg_ready = 0 while rst is high.
- First service after rst deasserts is slot 0 on the first rising edge.
- Latency:
  - Config is accepted on edge N; active is high after edge N.
  - The channel is first serviced at its next slot occurrence, which is 1..CHANNELS-1 cycles later.
  - expire and cur_value are registered, one cycle after the servicing edge.
- Simultaneous expiry of several channels cannot occur; expire is one-hot or zero.
- Reset mid-operation clears all state immediately, including any pending expire pulse.

## Configuration
- Macro: TC_TIMER_HOLD_EN.
- Defined: the hold port exists. While hold = 1:
  - The slot pointer, counts and cur_* freeze.
  - expire is 0.
  - cfg_ready still follows the frozen slot, so configuration writes are still accepted.
- Undefined: no hold port; behaviour is identical to hold tied to 0.

## Test plan
- Reset then idle 10 cycles: active=0, expire=0 throughout; cur_chan steps 0,1,2,3,0…; cfg_ready=0 during rst.
- Arm ch2, period=3, periodic, CHANNELS=4: expire[2] pulses every 12 cycles. The first pulse is 3 service slots after acceptance. cur_value for ch2 reads 2,1,3,2,1,3….
- Arm ch1, period=0, one-shot: exactly one expire[1] pulse at its first service slot; active[1] then clears.
- Assert cfg_valid for ch0 while slot=0: cfg_ready=0. Hold the request: it is accepted the next cycle with cfg_ready=1.
- Arm ch3 period=5 periodic, then stop it after 2 services: no further expire[3]; active[3]=0; cur_value shows 0 at the next ch3 slot.
- With TC_TIMER_HOLD_EN, ch0 period=2 armed: assert hold for 7 cycles mid-count. Expire is delayed by exactly 7 cycles, and a config write made during hold is accepted.
